// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and constants for the multi-word add/subtract sequencer.
package mwadd_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow: equal operand signs but a different result sign.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Command/result handshake bundle between ALU issue logic and the sequencer.
interface multiword_add_sequencer_if #(parameter int unsigned WORDS = 4);

    logic                    start_valid;
    logic                    start_ready;
    logic                    op_sub;
    logic [WORDS*32-1:0]     a;
    logic [WORDS*32-1:0]     b;
    logic                    cin;
    logic                    res_valid;
    logic                    res_ready;
    logic [WORDS*32-1:0]     sum;
    logic                    cout;
    logic                    overflow;
    logic                    busy;

    modport master (
        output start_valid, op_sub, a, b, cin, res_ready,
        input  start_ready, res_valid, sum, cout, overflow, busy
    );

    modport slave (
        input  start_valid, op_sub, a, b, cin, res_ready,
        output start_ready, res_valid, sum, cout, overflow, busy
    );

endinterface

// File: rtl/multiword_add_sequencer_csa.sv
// 32-bit carry-select adder: four 8-bit blocks, each precomputed for both carry-ins.
module carry_select_adder
    import mwadd_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    localparam int unsigned BLK_W = 8;
    localparam int unsigned NBLK  = WORD_W / BLK_W;

    logic [BLK_W:0] w_s0 [NBLK];
    logic [BLK_W:0] w_s1 [NBLK];
    logic [NBLK:0]  w_c;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        assign w_s0[g] = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]};
        assign w_s1[g] = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]} + 9'd1;
    end

    // Select each block's precomputed result with the carry rippling out of the block below.
    always_comb begin
        w_c    = {(NBLK+1){1'b0}};
        w_c[0] = cin;
        sum    = {WORD_W{1'b0}};
        for (int i = 0; i < NBLK; i++) begin
            if (w_c[i]) begin
                sum[i*BLK_W +: BLK_W] = w_s1[i][BLK_W-1:0];
                w_c[i+1]              = w_s1[i][BLK_W];
            end else begin
                sum[i*BLK_W +: BLK_W] = w_s0[i][BLK_W-1:0];
                w_c[i+1]              = w_s0[i][BLK_W];
            end
        end
        cout = w_c[NBLK];
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds or subtracts WORDS*32-bit operands one 32-bit word per cycle, LSW first,
// through a single carry-select adder with a registered inter-word carry.
module multiword_add_sequencer
    import mwadd_pkg::*;
#(
    parameter int unsigned WORDS = 4
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    multiword_add_sequencer_if.slave bus
);

    localparam int unsigned      W        = WORDS * WORD_W;
    localparam int unsigned      IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_step;
    logic              w_last;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic              r_start_ready;
    logic              r_res_valid;
    logic              r_busy;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] w_sum;
    logic              w_cout;

    // Operands shift right one word per step, so the adder always sees the low word.
    carry_select_adder u_adder (
        .a    (r_a[WORD_W-1:0]),
        .b    (r_b[WORD_W-1:0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake/status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_ready <= 1'b1;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_start_ready <= (w_state_nxt == IDLE);
            r_res_valid   <= (w_state_nxt == DONE);
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    // Operand capture, per-word accumulation, final carry and overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_sum   <= {W{1'b0}};
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= {IDX_W{1'b0}};
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b ^ {W{bus.op_sub}};
            r_carry <= bus.op_sub ? 1'b1 : bus.cin;
            r_idx   <= {IDX_W{1'b0}};
        end else if (w_step) begin
            r_a     <= {{WORD_W{1'b0}}, r_a[W-1:WORD_W]};
            r_b     <= {{WORD_W{1'b0}}, r_b[W-1:WORD_W]};
            r_sum   <= {w_sum, r_sum[W-1:WORD_W]};
            r_carry <= w_cout;
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= signed_ovf(r_a[WORD_W-1], r_b[WORD_W-1], w_sum[WORD_W-1]);
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

    assign bus.start_ready = r_start_ready;
    assign bus.res_valid   = r_res_valid;
    assign bus.busy        = r_busy;
    assign bus.sum         = r_sum;
    assign bus.cout        = r_cout;
    assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (WORDS=4) against a 129-bit arithmetic model.
module tb_multiword_add_sequencer;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = WORDS * 32;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   cyc;
    int   accept_cyc;

    multiword_add_sequencer_if #(.WORDS(WORDS)) bus ();

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain wide arithmetic; subtract carry-out means "no borrow" (a >= b unsigned).
    function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                      input logic sub, output logic [W-1:0] s, output logic co,
                                      output logic ov);
        logic [W:0] t;
        if (sub) begin
            t  = {1'b0, a} - {1'b0, b};
            s  = t[W-1:0];
            co = (a >= b);
            ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            s  = t[W-1:0];
            co = t[W];
            ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*32 +: 32] = 32'hFFFF_FFFF;
                1:       v[i*32 +: 32] = 32'h0000_0000;
                default: v[i*32 +: 32] = $urandom;
            endcase
        end
        return v;
    endfunction

    // Drives one command; returns #1 after the accepting edge with inputs scrambled.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        bus.a = a; bus.b = b; bus.cin = cin; bus.op_sub = sub; bus.start_valid = 1'b1;
        @(posedge clk);
        accept_cyc = cyc;
        #1;
        bus.start_valid = 1'b0;
        bus.a = rand_operand(); bus.b = rand_operand();
        bus.cin = 1'($urandom); bus.op_sub = 1'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_valid = 1'b0; bus.res_ready = 1'b0; bus.op_sub = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got=%b exp=1", bus.start_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.sum !== {W{1'b0}}) begin errors++; $display("FAIL reset_sum got=%h exp=0", bus.sum); end
        checks++; if ({bus.cout, bus.overflow} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf got=%b%b exp=00", bus.cout, bus.overflow); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic [W-1:0] ts [5];
        logic         tc [5];
        logic         tsub [5];
        logic         tco [5];
        logic         tov [5];
        int           lat;
        ta[0] = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}; tb[0] = 128'd1; tc[0] = 1'b0; tsub[0] = 1'b0;
        ts[0] = {64'h1, 64'h0};                  tco[0] = 1'b0;  tov[0] = 1'b0;
        ta[1] = {1'b0, {(W-1){1'b1}}};            tb[1] = 128'd1; tc[1] = 1'b0; tsub[1] = 1'b0;
        ts[1] = {1'b1, {(W-1){1'b0}}};            tco[1] = 1'b0;  tov[1] = 1'b1;
        ta[2] = 128'd0;                           tb[2] = 128'd1; tc[2] = 1'b0; tsub[2] = 1'b1;
        ts[2] = {W{1'b1}};                        tco[2] = 1'b0;  tov[2] = 1'b0;
        ta[3] = 128'd5;                           tb[3] = 128'd3; tc[3] = 1'b1; tsub[3] = 1'b1;
        ts[3] = 128'd2;                           tco[3] = 1'b1;  tov[3] = 1'b0;
        ta[4] = {W{1'b1}};                        tb[4] = {W{1'b1}}; tc[4] = 1'b1; tsub[4] = 1'b0;
        ts[4] = {W{1'b1}};                        tco[4] = 1'b1;  tov[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i], tc[i], tsub[i]);
            wait_valid(lat);
            checks++; if (lat != WORDS) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, WORDS); end
            checks++; if (bus.sum !== ts[i]) begin errors++; $display("FAIL dir%0d_sum got=%h exp=%h", i, bus.sum, ts[i]); end
            checks++; if (bus.cout !== tco[i] || bus.overflow !== tov[i]) begin errors++; $display("FAIL dir%0d_flags got=%b%b exp=%b%b", i, bus.cout, bus.overflow, tco[i], tov[i]); end
            handshake();
            checks++; if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_idle got=%b%b exp=01", i, bus.res_valid, bus.start_ready); end
        end
    endtask

    task automatic test_random(input int n);
        logic [W-1:0] a, b, es;
        logic         cin, sub, eco, eov;
        int           lat;
        for (int i = 0; i < n; i++) begin
            a = rand_operand(); b = rand_operand(); cin = 1'($urandom); sub = 1'($urandom);
            ref_model(a, b, cin, sub, es, eco, eov);
            issue(a, b, cin, sub);
            wait_valid(lat);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            checks++; if (lat != WORDS) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, WORDS); end
            checks++; if (bus.sum !== es || bus.cout !== eco || bus.overflow !== eov) begin
                errors++; $display("FAIL rnd%0d_result got=%h/%b/%b exp=%h/%b/%b", i, bus.sum, bus.cout, bus.overflow, es, eco, eov);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, es;
        logic         eco, eov;
        int           lat;
        a = {32'h8000_0000, 96'h1}; b = {32'h8000_0000, 96'h2};
        ref_model(a, b, 1'b0, 1'b0, es, eco, eov);
        issue(a, b, 1'b0, 1'b0);
        wait_valid(lat);
        for (int k = 0; k < 5; k++) begin
            bus.start_valid = (k == 2);
            @(posedge clk); #1;
            bus.start_valid = 1'b0;
            checks++; if (bus.sum !== es || bus.cout !== eco || bus.overflow !== eov || bus.res_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d got=%h/%b/%b/%b exp=%h/%b/%b/1", k, bus.sum, bus.cout, bus.overflow, bus.res_valid, es, eco, eov);
            end
            checks++; if (bus.start_ready !== 1'b0) begin errors++; $display("FAIL bp_start_ready%0d got=%b exp=0", k, bus.start_ready); end
        end
        handshake();
        checks++; if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL bp_idle got busy=%b ready=%b valid=%b exp=0/1/0", bus.busy, bus.start_ready, bus.res_valid);
        end
        a = rand_operand(); b = rand_operand();
        ref_model(a, b, 1'b1, 1'b0, es, eco, eov);
        issue(a, b, 1'b1, 1'b0);
        wait_valid(lat);
        checks++; if (lat != WORDS || bus.sum !== es || bus.cout !== eco || bus.overflow !== eov) begin
            errors++; $display("FAIL bp_next got lat=%0d %h/%b/%b exp lat=%0d %h/%b/%b", lat, bus.sum, bus.cout, bus.overflow, WORDS, es, eco, eov);
        end
        handshake();
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] a, b, es;
        logic         eco, eov;
        int           lat;
        issue(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== {W{1'b0}}) begin
            errors++; $display("FAIL midrst_async got valid=%b busy=%b sum=%h exp=0/0/0", bus.res_valid, bus.busy, bus.sum);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b/%b exp=1/0", bus.start_ready, bus.busy); end
        a = rand_operand(); b = rand_operand();
        ref_model(a, b, 1'b0, 1'b1, es, eco, eov);
        issue(a, b, 1'b0, 1'b1);
        wait_valid(lat);
        checks++; if (lat != WORDS || bus.sum !== es || bus.cout !== eco || bus.overflow !== eov) begin
            errors++; $display("FAIL midrst_next got lat=%0d %h/%b/%b exp lat=%0d %h/%b/%b", lat, bus.sum, bus.cout, bus.overflow, WORDS, es, eco, eov);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, es;
        logic         eco, eov;
        int           lat;
        int           prev;
        prev = -1;
        for (int i = 0; i < 3; i++) begin
            a = rand_operand(); b = rand_operand();
            ref_model(a, b, 1'b0, 1'(i), es, eco, eov);
            issue(a, b, 1'b0, 1'(i));
            if (prev >= 0) begin
                checks++; if (accept_cyc - prev != WORDS + 2) begin errors++; $display("FAIL b2b%0d_interval got=%0d exp=%0d", i, accept_cyc - prev, WORDS + 2); end
            end
            prev = accept_cyc;
            bus.res_ready = 1'b1;
            wait_valid(lat);
            checks++; if (lat != WORDS || bus.sum !== es || bus.cout !== eco || bus.overflow !== eov) begin
                errors++; $display("FAIL b2b%0d_result got lat=%0d %h/%b/%b exp %h/%b/%b", i, lat, bus.sum, bus.cout, bus.overflow, es, eco, eov);
            end
            @(posedge clk); #1;
            bus.res_ready = 1'b0;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        accept_cyc = 0;
        test_reset();
        test_directed();
        test_random(40);
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
